// File: rtl/top_level_wrapper.sv
// SHA-1 single-block accelerator behind a small word-addressed register bus.
// Holds 16 message words and, on START, hashes them as one already-padded
// block. It uses one round per clock and a rolling 16-word message schedule.
// The five digest words change only when a hash completes.
module top_level_wrapper (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  localparam logic [31:0] IV0 = 32'h6745_2301;
  localparam logic [31:0] IV1 = 32'hEFCD_AB89;
  localparam logic [31:0] IV2 = 32'h98BA_DCFE;
  localparam logic [31:0] IV3 = 32'h1032_5476;
  localparam logic [31:0] IV4 = 32'hC3D2_E1F0;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  state_t      state, state_next;
  logic [31:0] msg [16];
  logic [31:0] h   [5];
  logic [31:0] w   [16];
  logic [31:0] a, b, c, d, e;
  logic [6:0]  t;
  logic        busy, done;

  logic [4:0]  addr;
  logic [3:0]  msg_idx;
  logic        unused_addr;
  logic        start;
  logic        msg_we;
  logic [31:0] f_val, k_val, temp, w_new, rd_val;

  // Only the low five address bits select a register; the rest are don't-care.
  assign addr        = address[4:0];
  assign unused_addr = ^address[31:5];
  assign msg_idx     = 4'(addr - 5'd1);
  assign start       = write && (addr == 5'd0) && writedata[0] && (state == S_IDLE);
  assign msg_we      = write && !busy && (addr >= 5'd1) && (addr <= 5'd16);

  // Round function, constant, new working word and next schedule word.
  always_comb begin
    f_val = 32'd0;
    k_val = 32'd0;
    if (t < 7'd20) begin
      f_val = (b & c) | (~b & d);
      k_val = 32'h5A82_7999;
    end else if (t < 7'd40) begin
      f_val = b ^ c ^ d;
      k_val = 32'h6ED9_EBA1;
    end else if (t < 7'd60) begin
      f_val = (b & c) | (b & d) | (c & d);
      k_val = 32'h8F1B_BCDC;
    end else begin
      f_val = b ^ c ^ d;
      k_val = 32'hCA62_C1D6;
    end
    temp  = rotl5(a) + f_val + e + k_val + w[0];
    w_new = rotl1(w[13] ^ w[8] ^ w[2] ^ w[0]);
  end

  // Read-side register mux; the value is captured into readdata on a read.
  always_comb begin
    rd_val = 32'd0;
    case (addr)
      5'd0:    rd_val = {30'd0, done, busy};
      5'd17:   rd_val = h[0];
      5'd18:   rd_val = h[1];
      5'd19:   rd_val = h[2];
      5'd20:   rd_val = h[3];
      5'd21:   rd_val = h[4];
      default: begin
        if (addr <= 5'd16) rd_val = msg[msg_idx];
        else               rd_val = 32'd0;
      end
    endcase
  end

  // FSM next-state: IDLE -> INIT -> 80 x ROUND -> FINAL -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_INIT;
        else       state_next = S_IDLE;
      end
      S_INIT:  state_next = S_ROUND;
      S_ROUND: begin
        if (t == 7'd79) state_next = S_FINAL;
        else            state_next = S_ROUND;
      end
      S_FINAL: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Bus registers, hash datapath and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        msg[i] <= 32'd0;
        w[i]   <= 32'd0;
      end
      for (int i = 0; i < 5; i++) h[i] <= 32'd0;
      a    <= 32'd0;
      b    <= 32'd0;
      c    <= 32'd0;
      d    <= 32'd0;
      e    <= 32'd0;
      t    <= 7'd0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      // Read captures pre-write contents since msg updates are non-blocking.
      if (read) readdata <= rd_val;
      if (msg_we) msg[msg_idx] <= writedata;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        S_INIT: begin
          for (int i = 0; i < 16; i++) w[i] <= msg[i];
          a <= IV0;
          b <= IV1;
          c <= IV2;
          d <= IV3;
          e <= IV4;
          t <= 7'd0;
        end
        S_ROUND: begin
          e <= d;
          d <= c;
          c <= rotl30(b);
          b <= a;
          a <= temp;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          t <= t + 7'd1;
        end
        S_FINAL: begin
          h[0] <= IV0 + a;
          h[1] <= IV1 + b;
          h[2] <= IV2 + c;
          h[3] <= IV3 + d;
          h[4] <= IV4 + e;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_level_wrapper.sv
// Scoreboard bench for the SHA-1 accelerator: reads push their expected
// value when issued and are compared when readdata appears one edge later.
module tb_top_level_wrapper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write;
  logic        read;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] cur_msg [16];
  logic [159:0] abc_digest = {32'hA9993E36, 32'h4706816A, 32'hBA3E2571,
                              32'h7850C26C, 32'h9CD0D89D};

  top_level_wrapper dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .write     (write),
    .read      (read),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Independent SHA-1 compression of one padded block, using a full 80-word schedule.
  function automatic logic [159:0] sha1_model(input logic [511:0] blk);
    logic [31:0] wv [80];
    logic [31:0] va, vb, vc, vd, ve, f, k, tmp, x;
    for (int i = 0; i < 16; i++) wv[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = wv[i-3] ^ wv[i-8] ^ wv[i-14] ^ wv[i-16];
      wv[i] = {x[30:0], x[31]};
    end
    va = 32'h67452301; vb = 32'hEFCDAB89; vc = 32'h98BADCFE;
    vd = 32'h10325476; ve = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (vb & vc) | (~vb & vd);           k = 32'h5A827999; end
      else if (i < 40) begin f = vb ^ vc ^ vd;                     k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (vb & vc) | (vb & vd) | (vc & vd); k = 32'h8F1BBCDC; end
      else             begin f = vb ^ vc ^ vd;                     k = 32'hCA62C1D6; end
      tmp = {va[26:0], va[31:27]} + f + ve + k + wv[i];
      ve = vd; vd = vc; vc = {vb[1:0], vb[31:2]}; vb = va; va = tmp;
    end
    return {va + 32'h67452301, vb + 32'hEFCDAB89, vc + 32'h98BADCFE,
            vd + 32'h10325476, ve + 32'hC3D2E1F0};
  endfunction

  // All bus tasks start and end at a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] dat);
    write = 1'b1; address = a; writedata = dat;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e_v;
    string       t_v;
    read = 1'b1; address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    read = 1'b0;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e_v = exp_q.pop_front();
      t_v = tag_q.pop_front();
      check_val(t_v, readdata, e_v);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_msg();
    for (int i = 0; i < 16; i++) wr(32'(i + 1), cur_msg[i]);
  endtask

  task automatic read_digest(input logic [159:0] dg, input string tag);
    for (int i = 0; i < 5; i++) rd(32'(17 + i), dg[159 - 32*i -: 32], tag);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_msg[i] = 32'd0;
    cur_msg[0]  = 32'h61626380;
    cur_msg[15] = 32'h00000018;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] blk;
    logic [159:0] rnd_digest;
    reset_n = 1'b0; write = 1'b0; read = 1'b0;
    address = 32'd0; writedata = 32'd0;
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // Reset state
    check_val("reset_readdata", readdata, 32'd0);
    rd(32'd0,  32'd0, "reset_status");
    rd(32'd1,  32'd0, "reset_m0");
    rd(32'd17, 32'd0, "reset_h0");
    rd(32'd21, 32'd0, "reset_h4");

    // Unmapped and readback, upper address bits ignored
    rd(32'd25, 32'd0, "unmapped_25");
    wr(32'd25, 32'hDEADBEEF);
    rd(32'd25, 32'd0, "unmapped_25_after_write");
    wr(32'd5, 32'h12345678);
    rd(32'd5, 32'h12345678, "readback_5");
    rd(32'hFFFF_FFE5, 32'h12345678, "readback_5_high_bits");
    // Simultaneous read and write of the same word returns the old value
    read = 1'b1; write = 1'b1; address = 32'd5; writedata = 32'hCAFEF00D;
    exp_q.push_back(32'h12345678); tag_q.push_back("rw_same_addr_old");
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check_val(tag_q.pop_front(), readdata, exp_q.pop_front());
    @(negedge clk);
    rd(32'd5, 32'hCAFEF00D, "rw_same_addr_new");
    // Holding read low keeps readdata
    idle(2);
    check_val("readdata_hold", readdata, 32'hCAFEF00D);

    // Known-answer test with status timing
    set_abc();
    load_msg();
    wr(32'd0, 32'd1);
    rd(32'd0, 32'd1, "status_busy_after_start");
    idle(80);
    rd(32'd0, 32'd1, "status_busy_edge82_pre");
    rd(32'd0, 32'd2, "status_done");
    read_digest(abc_digest, "kat_abc");
    idle(5);
    rd(32'd0, 32'd2, "done_sticky");

    // Write protection while busy
    wr(32'd0, 32'd1);
    idle(10);
    wr(32'd1, 32'hFFFFFFFF);
    rd(32'd0, 32'd1, "busy_mid_hash");
    idle(90);
    read_digest(abc_digest, "busy_protect_digest");
    rd(32'd1, 32'h61626380, "busy_protect_m0");

    // Random block against the model; digest holds old value mid-hash
    for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = cur_msg[i];
    rnd_digest = sha1_model(blk);
    load_msg();
    wr(32'd0, 32'd1);
    idle(30);
    rd(32'd17, 32'hA9993E36, "digest_hold_mid_hash");
    idle(60);
    read_digest(rnd_digest, "random_block");

    // Reset mid-hash
    set_abc();
    load_msg();
    wr(32'd0, 32'd1);
    idle(40);
    #2 reset_n = 1'b0;
    #1 check_val("async_reset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(32'd0,  32'd0, "midreset_status");
    rd(32'd1,  32'd0, "midreset_m0");
    read_digest(160'd0, "midreset_digest");
    idle(100);
    rd(32'd0,  32'd0, "midreset_quiet_status");
    rd(32'd17, 32'd0, "midreset_quiet_h0");

    // Held START restarts after each completion; digest stays correct
    load_msg();
    write = 1'b1; address = 32'd0; writedata = 32'd1;
    idle(120);
    write = 1'b0;
    rd(32'd0, 32'd1, "held_start_rerun_busy");
    read_digest(abc_digest, "held_start_digest");
    idle(100);
    rd(32'd0, 32'd2, "held_start_final_done");
    read_digest(abc_digest, "held_start_final_digest");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/top_level_wrapper.md
TOP_LEVEL_WRAPPER -- requirements
Module: top_level_wrapper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state changes on its rising edge), and reset_n input 1 (asynchronous, active-low).
REQ-002 write  input  1  bus write strobe, sampled on the clk rising edge.
REQ-003 read  input  1  bus read strobe, sampled on the clk rising edge.
REQ-004 address  input  32  word address; only bits [4:0] are decoded, bits [31:5] are ignored.
REQ-005 writedata  input  32  write data.
REQ-006 readdata  output  32  registered read data.

Function (SHA-1 single-block accelerator)
REQ-007 The register map SHALL be as follows.
- 0: CONTROL/STATUS. On write, bit0 = START. On read, bit0 = BUSY, bit1 = DONE, other bits 0.
- 1..16: message words M0..M15, read/write. Address 1 = W0, the most significant word of the big-endian 512-bit block.
- 17..21: digest H0..H4, read-only.
- 22..31: unmapped; reads return 0, writes are ignored.
REQ-008 A write (write=1) to addresses 1..16 SHALL update the word at the rising edge, but only while BUSY=0; writes while BUSY=1 are ignored.
REQ-009 A write to address 0 with writedata[0]=1 while state is IDLE SHALL start a hash; such a write while BUSY=1 is ignored.
REQ-010 The block SHALL NOT pad the message; it hashes the 16 stored words as one already-padded block.
REQ-011 On every start, working and chaining values SHALL be initialised to the standard IV: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0. There is no chaining across starts.
REQ-012 The FSM SHALL have four states.
- IDLE: waits for START; START -> INIT, setting BUSY=1 and DONE=0.
- INIT (1 cycle): loads the 16-entry W shift register from M0..M15, loads A..E from the IV, sets t=0.
- ROUND (80 cycles, t=0..79): one SHA-1 round per cycle; at t=79 -> FINAL.
- FINAL (1 cycle): H0..H4 = IV + A..E (mod 2^32); DONE=1, BUSY=0; -> IDLE.
REQ-013 Round arithmetic SHALL be standard SHA-1, all additions mod 2^32.
- f: t<20 (B&C)|(~B&D), K 5A827999; t<40 B^C^D, K 6ED9EBA1; t<60 (B&C)|(B&D)|(C&D), K 8F1BBCDC; else B^C^D, K CA62C1D6.
- TEMP = rotl5(A) + f + E + K + Wt; E=D, D=C, C=rotl30(B), B=A, A=TEMP.
- Schedule: Wt for t>=16 = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), produced on the fly in a 16-word shift register.
REQ-014 Latency: DONE and the new digest SHALL be visible at the 82nd rising edge after the edge that accepted START.
REQ-015 H0..H4 SHALL change only in FINAL. While a later hash runs, they hold the previous result.
REQ-016 A START held asserted continuously SHALL simply restart the hash from IDLE after each completion. Because digest updates occur only in FINAL, the digest remains correct throughout.
REQ-017 Reads: when read=1 at a rising edge, readdata SHALL register the addressed value, with one-cycle latency.
- When read=0, readdata holds its value.
- On a simultaneous read and write to the same address, readdata returns the pre-write value.
REQ-018 DONE SHALL stay 1 until the next accepted START.

Reset
REQ-019 While reset_n=0 the block SHALL asynchronously clear the following, and SHALL remain in IDLE after reset_n rises.
- readdata, M0..M15, H0..H4, A..E, W and t all to 0.
- BUSY=0, DONE=0, state=IDLE.
REQ-020 Reset asserted mid-hash SHALL abort the hash immediately, with no digest update.

Verification
REQ-021 Known-answer test: after reset, write M0=61626380, M1..M14=0, M15=00000018; write addr0=1; wait 100 cycles; read 17..21 -> A9993E36, 4706816A, BA3E2571, 7850C26C, 9CD0D89D.
REQ-022 Status timing: read addr0 one cycle after START -> 1 (BUSY); after 82 cycles -> 2 (DONE).
REQ-023 Held start: keep write=1, address=0, writedata=1 for 120 cycles, then read 17..21 -> the same "abc" digest as REQ-021.
REQ-024 Busy write protection: during BUSY, write addr1=FFFFFFFF -> ignored; the digest is still the "abc" value and readback of addr1 gives 61626380.
REQ-025 Reset mid-hash: pulse reset_n low at cycle 40 of a hash -> all reads return 0, status 0, no further activity.
REQ-026 Unmapped/readback: read addr 25 -> 0; write addr5=12345678, then read addr5 -> 12345678 one cycle after read.
